// File: rtl/mfp_seven_segment_pkg.sv
// Shared constants for the multiplexed seven-segment driver.
// Glyphs are active-high {g,f,e,d,c,b,a}; index is the hex nibble.
package mfp_seven_segment_pkg;

  localparam int MFP_N_7SEG_DIGITS_MAX = 16;
  localparam int MFP_7SEG_IDX_W = $clog2(MFP_N_7SEG_DIGITS_MAX);

  typedef logic [MFP_7SEG_IDX_W-1:0] digit_idx_t;

  localparam logic [15:0][6:0] MFP_7SEG_GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/mfp_seven_segment_scan_counter.sv
// Slot/digit scan counter: cnt runs 0..REFRESH_DIV-1, idx steps per slot.
// snap marks the last cycle of a frame, when the inputs are captured.
import mfp_seven_segment_pkg::*;

module mfp_seven_segment_scan_counter #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  output digit_idx_t idx,
  output logic       slot_first,
  output logic       slot_end,
  output logic       snap
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam digit_idx_t LAST_IDX = digit_idx_t'(N_DIGITS - 1);

  logic [CNT_W-1:0] cnt;

  assign slot_first = (cnt == '0);
  assign slot_end   = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign snap       = slot_end && (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == LAST_IDX) ? '0 : idx + digit_idx_t'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mfp_multi_digit_seven_segment_display.sv
// Time-multiplexed N-digit seven-segment driver with PWM dimming.
// Define MFP_SEVEN_SEGMENT_LZB_EN to build in leading-zero blanking.
import mfp_seven_segment_pkg::*;

module mfp_multi_digit_seven_segment_display #(
  parameter int N_DIGITS         = 8,
  parameter int REFRESH_DIV      = 50000,
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] number,
  input  logic [N_DIGITS-1:0]   dots,
  input  logic                  blank_lz,
  input  logic [3:0]            brightness,
  output logic [6:0]            seven_segments,
  output logic                  dot,
  output logic [N_DIGITS-1:0]   digit_sel,
  output logic                  frame_start
);

  localparam logic [N_DIGITS-1:0] SEL_OFF =
    {N_DIGITS{DIGIT_ACTIVE_LOW}};
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};

  digit_idx_t idx;
  logic slot_first;
  logic slot_end;
  logic snap;

  mfp_seven_segment_scan_counter #(
    .N_DIGITS    (N_DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_scan (
    .clk        (clk),
    .rst        (rst),
    .idx        (idx),
    .slot_first (slot_first),
    .slot_end   (slot_end),
    .snap       (snap)
  );

  logic [4*N_DIGITS-1:0] num_q;
  logic [N_DIGITS-1:0]   dots_q;
  logic                  armed;
  logic [3:0]            pwm;

  // armed suppresses frame_start for the all-zero frame after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      num_q  <= '0;
      dots_q <= '0;
      armed  <= 1'b0;
    end else if (snap) begin
      num_q  <= number;
      dots_q <= dots;
      armed  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pwm <= 4'd0;
    else     pwm <= pwm + 4'd1;
  end

  logic blank;

`ifdef MFP_SEVEN_SEGMENT_LZB_EN
  logic blz_q;
  logic zero_run;

  always_ff @(posedge clk) begin
    if (rst)       blz_q <= 1'b0;
    else if (snap) blz_q <= blank_lz;
  end

  always_comb begin
    blank    = 1'b0;
    zero_run = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (num_q[4*i +: 4] == 4'h0);
      if (idx == digit_idx_t'(i)) blank = blz_q && zero_run;
    end
  end
`else
  logic blank_lz_unused;
  assign blank_lz_unused = blank_lz;
  assign blank = 1'b0;
`endif

  logic                lit;
  logic [3:0]          nib;
  logic                dot_raw;
  logic [N_DIGITS-1:0] sel_d;
  logic [6:0]          seg_d;
  logic                dot_d;
  logic                fs_d;

  assign lit  = (brightness == 4'hF) || (pwm < brightness);
  assign fs_d = armed && slot_first && (idx == '0);

  always_comb begin
    nib     = 4'h0;
    dot_raw = 1'b0;
    sel_d   = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == digit_idx_t'(i)) begin
        nib      = num_q[4*i +: 4];
        dot_raw  = dots_q[i];
        sel_d[i] = lit;
      end
    end
    seg_d = (lit && !blank) ? MFP_7SEG_GLYPHS[nib] : 7'h00;
    dot_d = lit && !blank && dot_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_sel      <= SEL_OFF;
      seven_segments <= SEG_OFF;
      dot            <= SEG_ACTIVE_LOW;
      frame_start    <= 1'b0;
    end else begin
      digit_sel      <= sel_d ^ SEL_OFF;
      seven_segments <= seg_d ^ SEG_OFF;
      dot            <= dot_d ^ SEG_ACTIVE_LOW;
      frame_start    <= fs_d;
    end
  end

endmodule

// File: tb/tb_mfp_multi_digit_seven_segment_display.sv
// Scoreboard bench for the multiplexed seven-segment driver.
// Predictor models the display from elapsed cycles since reset.
module tb_mfp_multi_digit_seven_segment_display;

  localparam int N  = 8;
  localparam int R  = 4;
  localparam int NR = N * R;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [7:0] sel;
    logic [6:0] seg;
    logic       dot;
    logic       fs;
  } out_t;

  localparam out_t IDLE = '{sel: 8'hFF, seg: 7'h7F, dot: 1'b1, fs: 1'b0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] number = '0;
  logic [7:0]  dots = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  brightness = 4'hF;
  logic [6:0]  seven_segments;
  logic        dot;
  logic [7:0]  digit_sel;
  logic        frame_start;

  always #5 clk = ~clk;

  mfp_multi_digit_seven_segment_display #(
    .N_DIGITS         (N),
    .REFRESH_DIV      (R),
    .SEG_ACTIVE_LOW   (1'b1),
    .DIGIT_ACTIVE_LOW (1'b1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .number         (number),
    .dots           (dots),
    .blank_lz       (blank_lz),
    .brightness     (brightness),
    .seven_segments (seven_segments),
    .dot            (dot),
    .digit_sel      (digit_sel),
    .frame_start    (frame_start)
  );

  int n_checks = 0;
  int n_fail   = 0;

  out_t exp_q[$];

  int          k = 0;
  logic [31:0] m_num = '0;
  logic [7:0]  m_dots = '0;
  logic        m_blz = 1'b0;

  function automatic out_t predict(int kk, logic [3:0] br);
    out_t o;
    int   d;
    int   p;
    bit   on;
    bit   dark;
    logic [31:0] upper;
    d     = (kk / R) % N;
    p     = kk % 16;
    on    = (br == 4'hF) || (p < int'(br));
    upper = m_num >> (4 * d);
    dark  = 1'b0;
`ifdef MFP_SEVEN_SEGMENT_LZB_EN
    dark  = m_blz && (d != 0) && (upper == 0);
`endif
    o.sel = on ? ~(8'd1 << d) : 8'hFF;
    o.seg = (on && !dark) ? ~GLYPH[upper[3:0]] : 7'h7F;
    o.dot = !(on && !dark && m_dots[d]);
    o.fs  = ((kk % NR) == 0) && (kk >= NR);
    return o;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_q.push_back(IDLE);
      k      <= 0;
      m_num  <= '0;
      m_dots <= '0;
      m_blz  <= 1'b0;
    end else begin
      exp_q.push_back(predict(k, brightness));
      if ((k % NR) == NR - 1) begin
        m_num  <= number;
        m_dots <= dots;
        m_blz  <= blank_lz;
      end
      k <= k + 1;
    end
  end

  initial begin : monitor
    out_t e;
    out_t a;
    @(posedge clk);
    forever begin
      @(negedge clk);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        a = {digit_sel, seven_segments, dot, frame_start};
        if (a !== e) begin
          n_fail++;
          $display("FAIL scoreboard t=%0t got sel=%b seg=%b dot=%b fs=%b expected sel=%b seg=%b dot=%b fs=%b",
                   $time, a.sel, a.seg, a.dot, a.fs,
                   e.sel, e.seg, e.dot, e.fs);
        end
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic wait_k(int m, string name);
    int c;
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while ((k % NR) != m && c < 3 * NR);
    if ((k % NR) != m) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_%s: got k=%0d expected slot %0d", name, k, m);
    end
  endtask

  task automatic measure_frame(output int seg_lit, output int dot_lit);
    seg_lit = 0;
    dot_lit = 0;
    repeat (NR) begin
      @(posedge clk);
      @(negedge clk);
      if (seven_segments != 7'h7F) seg_lit++;
      if (dot == 1'b0) dot_lit++;
    end
  endtask

  initial begin : stimulus
    logic [6:0] g;
    int cnt_a;
    int cnt_b;
    int br_tab [3];
    br_tab = '{0, 8, 15};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_sel", 32'(digit_sel), 32'hFF);
    check("reset_seg", 32'(seven_segments), 32'h7F);
    check("reset_dot", 32'(dot), 32'h1);
    check("reset_fs", 32'(frame_start), 32'h0);

    rst = 1'b0;
    number = 32'h0000_1234;
    dots = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    g = ~GLYPH[0];
    check("first_digit_sel", 32'(digit_sel), 32'hFE);
    check("first_digit_seg", 32'(seven_segments), 32'(g));

    repeat (2 * NR) @(posedge clk);
    cnt_a = 0;
    cnt_b = 0;
    repeat (4 * NR) begin
      @(negedge clk);
      if (frame_start) cnt_a++;
      if (digit_sel == 8'hFE) cnt_b++;
    end
    check("frame_start_count", 32'(cnt_a), 32'd4);
    check("digit0_slot_cycles", 32'(cnt_b), 32'(4 * R));

    wait_k(R + 1, "antitear");
    number = 32'h0000_5678;
    wait_k(0, "antitear_next");
    @(posedge clk);
    @(negedge clk);
    g = ~GLYPH[8];
    check("antitear_new_frame", 32'(seven_segments), 32'(g));

    #1;
    number = 32'h0000_0A05;
    dots = 8'h80;
    blank_lz = 1'b1;
    wait_k(0, "lzb");
    measure_frame(cnt_a, cnt_b);
`ifdef MFP_SEVEN_SEGMENT_LZB_EN
    check("lzb_on_lit", 32'(cnt_a), 32'(3 * R));
    check("lzb_on_dot", 32'(cnt_b), 32'd0);
`else
    check("lzb_on_lit", 32'(cnt_a), 32'(8 * R));
    check("lzb_on_dot", 32'(cnt_b), 32'(R));
`endif
    #1;
    blank_lz = 1'b0;
    wait_k(0, "lzb_off");
    measure_frame(cnt_a, cnt_b);
    check("lzb_off_lit", 32'(cnt_a), 32'(8 * R));
    check("lzb_off_dot", 32'(cnt_b), 32'(R));

    foreach (br_tab[i]) begin
      #1;
      brightness = 4'(br_tab[i]);
      cnt_a = 0;
      repeat (64) begin
        @(posedge clk);
        @(negedge clk);
        if (digit_sel != 8'hFF) cnt_a++;
      end
      check($sformatf("brightness_%0d", br_tab[i]), 32'(cnt_a),
            32'(br_tab[i] == 15 ? 64 : br_tab[i] * 4));
    end

    repeat (600) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 9) == 0)
        number = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) dots = 8'($urandom);
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 19) == 0) brightness = 4'($urandom);
      rst = ($urandom_range(0, 249) == 0);
    end
    rst = 1'b0;

    brightness = 4'hF;
    wait_k(2 * R + 1, "midreset");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midreset_sel", 32'(digit_sel), 32'hFF);
    check("midreset_seg", 32'(seven_segments), 32'h7F);
    check("midreset_dot", 32'(dot), 32'h1);
    repeat (R) begin
      @(posedge clk);
      @(negedge clk);
      check("restart_digit0", 32'(digit_sel), 32'hFE);
    end
    @(posedge clk);
    @(negedge clk);
    check("restart_digit1", 32'(digit_sel), 32'hFD);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
